idle_frame_scanner: RTL
=======================

// Module: idle_frame_scanner
// PURPOSE
//  Sits directly upstream of idle_mem: it drives ram_addr_x/ram_addr_y/step into the sprite ROM
//  and turns its combinational 16-bit ram_data into a raster-ordered pixel stream.
//  Output is a valid/ready stream with SOF/EOL/EOF flags for the downstream LCD writer.
//  The block also owns the idle-animation step sequencing.
// PARAMETERS
//  H_PIXELS         132  pixels per line; ram_addr_x runs 0..H_PIXELS-1
//  V_PIXELS         162  lines per frame; ram_addr_y runs 0..V_PIXELS-1
//  NUM_STEPS        4    animation steps; step wraps NUM_STEPS-1 -> 0
//  FRAMES_PER_STEP  8    completed frames shown before step advances
// PORTS
//  clk         in   1   single system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   pulse; begin one frame when idle
//  abort       in   1   pulse; kill current frame
//  step        out  4   animation step to ROM
//  ram_addr_x  out  8   column address to ROM
//  ram_addr_y  out  8   row address to ROM
//  ram_data    in   16  RGB565 pixel from ROM (combinational in address)
//  px_data     out  16  registered pixel
//  px_valid    out  1   px_data/flags valid
//  px_ready    in   1   downstream accepts when px_valid&&px_ready
//  px_sof      out  1   with pixel (0,0)
//  px_eol      out  1   with pixel x=H_PIXELS-1
//  px_eof      out  1   with last pixel of frame
//  busy        out  1   high in STREAM/DRAIN
//  frame_done  out  1   one-cycle pulse after EOF pixel accepted
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; x=y=0; step=0; frame count=0.
//  FSM states: IDLE, STREAM, DRAIN.
//   IDLE->STREAM on start (x=y=0 already).
//   STREAM: load slot when (!px_valid || px_ready).
//     Load captures ram_data at current (x,y) into px_data, sets px_valid and the flags,
//     then advances x. At x=H_PIXELS-1: x<=0, y++.
//     Loading the last pixel -> DRAIN; x,y return to 0.
//   DRAIN: hold until EOF pixel is accepted -> IDLE, then pulse frame_done next cycle.
//  Latency: start sampled at edge N -> px_valid high after edge N+1 carrying (0,0).
//   With px_ready held high: one pixel per cycle, H_PIXELS*V_PIXELS accepts per frame.
//  Backpressure: while px_valid && !px_ready, px_data, flags and x/y hold stable.
//   ram_data is never re-sampled during a stall.
//  Step sequencing:
//   step is constant for the whole frame. It updates only on the EOF accept.
//   On that accept, frame count increments; at FRAMES_PER_STEP-1 it wraps to 0 and step increments.
//   step at NUM_STEPS-1 wraps to 0.
//  Boundaries:
//   - start while busy: ignored.
//   - start and abort in the same cycle: abort wins, stay IDLE.
//   - abort in STREAM/DRAIN: next edge px_valid=0, flags=0, x=y=0, ->IDLE.
//     No frame_done; step and frame count unchanged.
//   - abort in IDLE: no effect.
//   - rst_n low mid-frame: asynchronous clear to reset values; px_valid drops immediately.
//   - H_PIXELS=1: px_sof and px_eol are asserted together.
//  Widths: x,y counters 8 bits. H_PIXELS and V_PIXELS must each be <=256; elaborate-time check.
//   Frame count is $clog2(FRAMES_PER_STEP) bits, minimum 1.
// STRUCTURE
//  Shared package idle_pkg: state enum {IDLE,STREAM,DRAIN}, RGB565 pixel typedef,
//   default H_PIXELS/V_PIXELS constants shared with idle_mem.
//  One sub-module: idle_step_seq (frame counter + step wrap; inputs eof_accept, outputs step).
//  Raster counters, FSM and output register stay in the top.
// TESTING
//  1. H=4,V=2, ready=1, start -> 8 valid beats.
//     sof on beat0, eol on beats 3 and 7, eof on beat7, frame_done 1 cycle after beat7.
//  2. Stall: drop ready for 3 cycles on beat2 -> px_data/x/y frozen, no beat lost or duplicated.
//  3. FRAMES_PER_STEP=2, NUM_STEPS=3, 7 frames -> step sequence 0,0,1,1,2,2,0.
//     Step never changes mid-frame.
//  4. Abort at beat5 -> px_valid=0 next cycle, no frame_done.
//     Following start restarts at (0,0) with the same step.
//  5. start while busy, and start+abort together in IDLE -> ignored; no beats emitted.
//  6. Assert rst_n=0 mid-frame with ready=0 -> px_valid and all outputs 0 asynchronously.
//     After release, start gives a normal frame with step=0.

Source files
------------

// File: rtl/idle_pkg.sv
// Shared types and defaults for the idle-animation frame path (scanner and sprite ROM).
package idle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } px_flags_t;

  localparam int H_PIXELS_DEF = 132;
  localparam int V_PIXELS_DEF = 162;

  // Counter width that still gives one bit when only a single value is needed.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idle_step_seq.sv
// Animation step sequencer: counts completed frames, advances step every FRAMES_PER_STEP frames.
module idle_step_seq
  import idle_pkg::*;
#(
  parameter int NUM_STEPS       = 4,
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eof_accept,
  output logic [3:0] step
);

  localparam int FCW = cnt_width(FRAMES_PER_STEP);

  logic [FCW-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      step      <= '0;
    end else if (eof_accept) begin
      if (frame_cnt == FCW'(FRAMES_PER_STEP - 1)) begin
        frame_cnt <= '0;
        step      <= (step == 4'(NUM_STEPS - 1)) ? 4'd0 : step + 4'd1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/idle_frame_scanner.sv
// Walks the sprite ROM in raster order and emits a valid/ready pixel stream with SOF/EOL/EOF.
module idle_frame_scanner
  import idle_pkg::*;
#(
  parameter int H_PIXELS        = H_PIXELS_DEF,
  parameter int V_PIXELS        = V_PIXELS_DEF,
  parameter int NUM_STEPS       = 4,
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  step,
  output logic [7:0]  ram_addr_x,
  output logic [7:0]  ram_addr_y,
  input  logic [15:0] ram_data,
  output logic [15:0] px_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_sof,
  output logic        px_eol,
  output logic        px_eof,
  output logic        busy,
  output logic        frame_done
);

  if (H_PIXELS < 1 || H_PIXELS > 256 || V_PIXELS < 1 || V_PIXELS > 256) begin : g_bad_dims
    $error("idle_frame_scanner: H_PIXELS and V_PIXELS must be in 1..256");
  end
  if (NUM_STEPS < 1 || NUM_STEPS > 16 || FRAMES_PER_STEP < 1) begin : g_bad_steps
    $error("idle_frame_scanner: NUM_STEPS must be 1..16, FRAMES_PER_STEP >= 1");
  end

  state_t    state;
  logic [7:0] x, y;
  rgb565_t   px_q;
  px_flags_t flags;
  logic      x_last, y_last, load, eof_accept;

  assign x_last     = (x == 8'(H_PIXELS - 1));
  assign y_last     = (y == 8'(V_PIXELS - 1));
  assign load       = !px_valid || px_ready;
  assign eof_accept = (state == DRAIN) && px_valid && px_ready && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      px_q       <= '0;
      px_valid   <= 1'b0;
      flags      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) state <= STREAM;
        end
        STREAM: begin
          if (abort) begin
            state    <= IDLE;
            px_valid <= 1'b0;
            flags    <= '0;
            x        <= '0;
            y        <= '0;
          end else if (load) begin
            // ram_data is only sampled here, so a stall never re-reads the ROM.
            px_q      <= ram_data;
            px_valid  <= 1'b1;
            flags.sof <= (x == 8'd0) && (y == 8'd0);
            flags.eol <= x_last;
            flags.eof <= x_last && y_last;
            if (x_last) begin
              x <= '0;
              if (y_last) begin
                y     <= '0;
                state <= DRAIN;
              end else begin
                y <= y + 8'd1;
              end
            end else begin
              x <= x + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state    <= IDLE;
            px_valid <= 1'b0;
            flags    <= '0;
          end else if (px_ready) begin
            state      <= IDLE;
            px_valid   <= 1'b0;
            flags      <= '0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  idle_step_seq #(
    .NUM_STEPS      (NUM_STEPS),
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_step_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .eof_accept(eof_accept),
    .step      (step)
  );

  assign ram_addr_x = x;
  assign ram_addr_y = y;
  assign px_data    = px_q;
  assign px_sof     = flags.sof;
  assign px_eol     = flags.eol;
  assign px_eof     = flags.eof;
  assign busy       = (state != IDLE);

endmodule
